alu_seq: RTL and testbench

//  Parametrised, registered ALU with valid/ready handshakes on both sides; next-generation alu4.

---
 rtl/alu_seq_pkg.sv | 37 +++
 rtl/alu_seq_if.sv | 28 ++
 rtl/alu_seq_mul.sv | 54 +++++
 rtl/alu_seq.sv | 185 ++++++++++++++++++
 tb/tb_alu_seq.sv | 432 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_seq_pkg.sv
// Shared opcode map, flag bit positions and FSM state for the sequential ALU.
package alu_seq_pkg;

    localparam logic [4:0] OP_OR_A  = 5'd0;
    localparam logic [4:0] OP_XOR_A = 5'd1;
    localparam logic [4:0] OP_AND_A = 5'd2;
    localparam logic [4:0] OP_NOT_A = 5'd3;
    localparam logic [4:0] OP_INV_A = 5'd4;
    localparam logic [4:0] OP_NOT_B = 5'd5;
    localparam logic [4:0] OP_INV_B = 5'd6;
    localparam logic [4:0] OP_AND_B = 5'd7;
    localparam logic [4:0] OP_AND   = 5'd8;
    localparam logic [4:0] OP_OR    = 5'd9;
    localparam logic [4:0] OP_XOR   = 5'd10;
    localparam logic [4:0] OP_GT    = 5'd11;
    localparam logic [4:0] OP_LT    = 5'd12;
    localparam logic [4:0] OP_EQ    = 5'd13;
    localparam logic [4:0] OP_ADD   = 5'd14;
    localparam logic [4:0] OP_SUB   = 5'd15;
    localparam logic [4:0] OP_MUL   = 5'd16;

    localparam int F_ZERO  = 0;
    localparam int F_CARRY = 1;
    localparam int F_NEG   = 2;
    localparam int F_OVF   = 3;

    typedef enum logic {
        S_IDLE,
        S_MUL
    } state_t;

    function automatic logic op_legal(input logic [4:0] op,
                                      input bit mul_en);
        return (op < OP_MUL) || ((op == OP_MUL) && mul_en);
    endfunction

endpackage

// File: rtl/alu_seq_if.sv
// Command/result handshake bundle between producer, ALU and consumer.
interface alu_seq_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [4:0]       opcode;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] x;
    logic [WIDTH-1:0] y;
    logic [3:0]       flags;
    logic             err;
    logic             busy;

    modport master (
        output in_valid, opcode, a, b, out_ready,
        input  in_ready, out_valid, x, y, flags, err, busy
    );

    modport slave (
        input  in_valid, opcode, a, b, out_ready,
        output in_ready, out_valid, x, y, flags, err, busy
    );

endinterface

// File: rtl/alu_seq_mul.sv
// Shift-add unsigned multiplier, one partial product per cycle.
module alu_mul_seq #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               done,
    output logic [2*WIDTH-1:0] prod
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    logic [2*WIDTH-1:0] mcand_q;
    logic [2*WIDTH-1:0] acc_q;
    logic [2*WIDTH-1:0] acc_d;
    logic [WIDTH-1:0]   mplier_q;
    logic [CW-1:0]      cnt_q;
    logic               run_q;

    assign acc_d = mplier_q[0] ? acc_q + mcand_q : acc_q;
    // The final step's sum is handed out directly so the result
    // lands in the same edge that retires the last step.
    assign done  = run_q && (cnt_q == LAST);
    assign prod  = acc_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            mcand_q  <= '0;
            acc_q    <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
            run_q    <= 1'b0;
        end else if (start) begin
            mcand_q  <= {{WIDTH{1'b0}}, a};
            acc_q    <= '0;
            mplier_q <= b;
            cnt_q    <= '0;
            run_q    <= 1'b1;
        end else if (run_q) begin
            acc_q    <= acc_d;
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
            cnt_q    <= cnt_q + CW'(1);
            if (done) begin
                run_q <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/alu_seq.sv
// Registered ALU with valid/ready on both sides and a multi-cycle multiply.
module alu_seq
    import alu_seq_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter bit SIGNED_CMP = 1'b0,
    parameter bit MUL_EN     = 1'b1
) (
    input logic      clk,
    input logic      rst,
    alu_seq_if.slave bus
);

    state_t state_q;
    state_t state_d;

    logic in_ready;
    logic busy;
    logic accept;
    logic consume;
    logic is_mul;
    logic legal;
    logic mul_done;

    logic [2*WIDTH-1:0] mul_prod;
    logic [3:0]         mul_flags;

    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   diff;
    logic             gt;
    logic             lt;
    logic [WIDTH-1:0] r_x;
    logic [WIDTH-1:0] r_y;
    logic [3:0]       r_flags;
    logic             r_c;
    logic             r_v;

    logic             valid_q;
    logic [WIDTH-1:0] x_q;
    logic [WIDTH-1:0] y_q;
    logic [3:0]       flags_q;
    logic             err_q;

    assign is_mul  = MUL_EN && (bus.opcode == OP_MUL);
    assign legal   = op_legal(bus.opcode, MUL_EN);
    assign accept  = bus.in_valid && in_ready;
    assign consume = valid_q && bus.out_ready;

    alu_mul_seq #(
        .WIDTH (WIDTH)
    ) u_mul (
        .clk   (clk),
        .rst   (rst),
        .start (accept && is_mul),
        .a     (bus.a),
        .b     (bus.b),
        .done  (mul_done),
        .prod  (mul_prod)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: if (accept && is_mul) state_d = S_MUL;
            S_MUL:  if (mul_done)         state_d = S_IDLE;
        endcase
    end

    always_comb begin
        busy     = (state_q == S_MUL);
        in_ready = (state_q == S_IDLE) && (!valid_q || bus.out_ready);
    end

    always_comb begin
        sum  = {1'b0, bus.a} + {1'b0, bus.b};
        diff = {1'b0, bus.a} - {1'b0, bus.b};
        if (SIGNED_CMP) begin
            gt = $signed(bus.a) > $signed(bus.b);
            lt = $signed(bus.a) < $signed(bus.b);
        end else begin
            gt = bus.a > bus.b;
            lt = bus.a < bus.b;
        end
    end

    always_comb begin
        r_x = '0;
        r_y = '0;
        r_c = 1'b0;
        r_v = 1'b0;
        case (bus.opcode)
            OP_OR_A:  r_x[0] = |bus.a;
            OP_XOR_A: r_x[0] = ^bus.a;
            OP_AND_A: r_x[0] = &bus.a;
            OP_NOT_A: r_x[0] = !bus.a;
            OP_INV_A: r_x    = ~bus.a;
            OP_NOT_B: r_x[0] = !bus.b;
            OP_INV_B: r_x    = ~bus.b;
            OP_AND_B: r_x[0] = &bus.b;
            OP_AND:   r_x    = bus.a & bus.b;
            OP_OR:    r_x    = bus.a | bus.b;
            OP_XOR:   r_x    = bus.a ^ bus.b;
            OP_GT:    r_x[0] = gt;
            OP_LT:    r_x[0] = lt;
            OP_EQ:    r_x[0] = (bus.a == bus.b);
            OP_ADD: begin
                r_x    = sum[WIDTH-1:0];
                r_y[0] = sum[WIDTH];
                r_c    = sum[WIDTH];
                r_v    = (bus.a[WIDTH-1] == bus.b[WIDTH-1]) &&
                         (sum[WIDTH-1] != bus.a[WIDTH-1]);
            end
            OP_SUB: begin
                r_x = diff[WIDTH-1:0];
                r_y = {WIDTH{diff[WIDTH]}};
                r_c = diff[WIDTH];
                r_v = (bus.a[WIDTH-1] != bus.b[WIDTH-1]) &&
                      (diff[WIDTH-1] != bus.a[WIDTH-1]);
            end
            default: ;
        endcase
        if (!legal) begin
            r_x = bus.a;
            r_y = bus.b;
            r_c = 1'b0;
            r_v = 1'b0;
        end
    end

    always_comb begin
        r_flags = '0;
        if (legal) begin
            r_flags[F_ZERO]  = (r_x == '0);
            r_flags[F_NEG]   = r_x[WIDTH-1];
            r_flags[F_CARRY] = r_c;
            r_flags[F_OVF]   = r_v;
        end
        mul_flags         = '0;
        mul_flags[F_ZERO] = (mul_prod == '0);
        mul_flags[F_NEG]  = mul_prod[WIDTH-1];
    end

    // A multiply accepted during a consume falls through to the
    // consume branch, so the old result drains before MUL finishes.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            x_q     <= '0;
            y_q     <= '0;
            flags_q <= '0;
            err_q   <= 1'b0;
        end else if (accept && !is_mul) begin
            valid_q <= 1'b1;
            x_q     <= r_x;
            y_q     <= r_y;
            flags_q <= r_flags;
            err_q   <= !legal;
        end else if (mul_done) begin
            valid_q <= 1'b1;
            x_q     <= mul_prod[WIDTH-1:0];
            y_q     <= mul_prod[2*WIDTH-1:WIDTH];
            flags_q <= mul_flags;
            err_q   <= 1'b0;
        end else if (consume) begin
            valid_q <= 1'b0;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.busy      = busy;
    assign bus.out_valid = valid_q;
    assign bus.x         = x_q;
    assign bus.y         = y_q;
    assign bus.flags     = flags_q;
    assign bus.err       = err_q;

endmodule

// File: tb/tb_alu_seq.sv
// Bench for alu_seq: directed scenarios plus a randomized scoreboard run.
module tb_alu_seq;
    import alu_seq_pkg::*;

    typedef struct packed {
        logic [7:0] x;
        logic [7:0] y;
        logic [3:0] flags;
        logic       err;
    } res_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    alu_seq_if #(.WIDTH(8)) bus1 ();
    alu_seq_if #(.WIDTH(8)) bus2 ();

    alu_seq #(.WIDTH(8), .SIGNED_CMP(1'b0), .MUL_EN(1'b1)) dut1 (
        .clk (clk), .rst (rst), .bus (bus1)
    );
    alu_seq #(.WIDTH(8), .SIGNED_CMP(1'b1), .MUL_EN(1'b0)) dut2 (
        .clk (clk), .rst (rst), .bus (bus2)
    );

    function automatic res_t model(input logic [4:0] op,
                                   input logic [7:0] a,
                                   input logic [7:0] b,
                                   input bit scmp,
                                   input bit mul_en);
        res_t r;
        int ua, ub, sa, sb, t, st;
        logic [15:0] full;
        r    = '0;
        full = '0;
        ua   = int'(a);
        ub   = int'(b);
        sa   = int'($signed(a));
        sb   = int'($signed(b));
        if (op > 5'd16 || (op == 5'd16 && !mul_en)) begin
            r.x   = a;
            r.y   = b;
            r.err = 1'b1;
            return r;
        end
        case (op)
            OP_OR_A:  r.x = 8'(ua != 0);
            OP_XOR_A: r.x = 8'($countones(a) % 2);
            OP_AND_A: r.x = 8'(ua == 255);
            OP_NOT_A: r.x = 8'(ua == 0);
            OP_INV_A: r.x = 8'(255 - ua);
            OP_NOT_B: r.x = 8'(ub == 0);
            OP_INV_B: r.x = 8'(255 - ub);
            OP_AND_B: r.x = 8'(ub == 255);
            OP_AND:   r.x = a & b;
            OP_OR:    r.x = a | b;
            OP_XOR:   r.x = a ^ b;
            OP_GT:    r.x = 8'(scmp ? (sa > sb) : (ua > ub));
            OP_LT:    r.x = 8'(scmp ? (sa < sb) : (ua < ub));
            OP_EQ:    r.x = 8'(ua == ub);
            OP_ADD: begin
                t  = ua + ub;
                st = sa + sb;
                full = 16'(t);
                r.flags[F_CARRY] = (t > 255);
                r.flags[F_OVF]   = (st > 127) || (st < -128);
            end
            OP_SUB: begin
                t  = ua - ub;
                st = sa - sb;
                full = 16'(t);
                r.flags[F_CARRY] = (ua < ub);
                r.flags[F_OVF]   = (st > 127) || (st < -128);
            end
            OP_MUL: full = 16'(ua * ub);
            default: ;
        endcase
        if (op >= 5'd14) begin
            r.x = full[7:0];
            r.y = full[15:8];
        end
        r.flags[F_ZERO] = (op == 5'd16) ? (full == 16'h0) : (r.x == 8'h0);
        r.flags[F_NEG]  = r.x[7];
        return r;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic quiet();
        bus1.in_valid = 1'b0; bus1.opcode = '0; bus1.a = '0; bus1.b = '0;
        bus1.out_ready = 1'b1;
        bus2.in_valid = 1'b0; bus2.opcode = '0; bus2.a = '0; bus2.b = '0;
        bus2.out_ready = 1'b1;
    endtask

    task automatic test_reset();
        quiet();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        #1;
        checks++;
        if ({bus1.in_ready, bus1.out_valid, bus1.busy, bus1.err,
             bus1.flags, bus1.x, bus1.y} !== {4'b1000, 4'h0, 16'h0}) begin
            errors++;
            $display("FAIL reset1: rdy=%b vld=%b busy=%b err=%b fl=%b x=%h y=%h, want rdy=1 rest 0",
                     bus1.in_ready, bus1.out_valid, bus1.busy, bus1.err,
                     bus1.flags, bus1.x, bus1.y);
        end
        checks++;
        if ({bus2.in_ready, bus2.out_valid, bus2.busy} !== 3'b100) begin
            errors++;
            $display("FAIL reset2: rdy=%b vld=%b busy=%b, want 1 0 0",
                     bus2.in_ready, bus2.out_valid, bus2.busy);
        end
    endtask

    task automatic test_add();
        bus1.in_valid = 1'b1; bus1.opcode = OP_ADD;
        bus1.a = 8'hFF; bus1.b = 8'h01; bus1.out_ready = 1'b1;
        step();
        bus1.in_valid = 1'b0;
        checks++;
        if ({bus1.out_valid, bus1.x, bus1.y, bus1.flags, bus1.err} !==
            {1'b1, 8'h00, 8'h01, 4'b0011, 1'b0}) begin
            errors++;
            $display("FAIL add_carry: vld=%b x=%h y=%h fl=%b err=%b, want 1 00 01 0011 0",
                     bus1.out_valid, bus1.x, bus1.y, bus1.flags, bus1.err);
        end
        step();
        checks++;
        if (bus1.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL drain_drop: vld=%b, want 0", bus1.out_valid);
        end
    endtask

    task automatic test_sub();
        bus1.in_valid = 1'b1; bus1.opcode = OP_SUB;
        bus1.a = 8'h80; bus1.b = 8'h01;
        step();
        bus1.a = 8'h01; bus1.b = 8'h02;
        checks++;
        if ({bus1.out_valid, bus1.x, bus1.y, bus1.flags} !==
            {1'b1, 8'h7F, 8'h00, 4'b1000}) begin
            errors++;
            $display("FAIL sub_ovf: vld=%b x=%h y=%h fl=%b, want 1 7f 00 1000",
                     bus1.out_valid, bus1.x, bus1.y, bus1.flags);
        end
        step();
        bus1.in_valid = 1'b0;
        checks++;
        if ({bus1.out_valid, bus1.x, bus1.y, bus1.flags} !==
            {1'b1, 8'hFF, 8'hFF, 4'b0110}) begin
            errors++;
            $display("FAIL sub_borrow: vld=%b x=%h y=%h fl=%b, want 1 ff ff 0110",
                     bus1.out_valid, bus1.x, bus1.y, bus1.flags);
        end
        step();
    endtask

    task automatic test_mul();
        int cyc;
        int busy_n;
        bit rdy_seen;
        res_t e;
        bus1.in_valid = 1'b1; bus1.opcode = OP_MUL;
        bus1.a = 8'hFF; bus1.b = 8'hFF; bus1.out_ready = 1'b1;
        e = model(OP_MUL, 8'hFF, 8'hFF, 1'b0, 1'b1);
        step();
        bus1.in_valid = 1'b0;
        cyc = 1;
        busy_n = 0;
        rdy_seen = 1'b0;
        while (!bus1.out_valid && cyc < 20) begin
            if (bus1.busy) busy_n++;
            if (bus1.in_ready) rdy_seen = 1'b1;
            step();
            cyc++;
        end
        checks++;
        if (cyc !== 9) begin
            errors++;
            $display("FAIL mul_latency: got %0d cycles, want 9", cyc);
        end
        checks++;
        if (busy_n !== 8 || rdy_seen) begin
            errors++;
            $display("FAIL mul_busy: busy cycles %0d ready_seen %b, want 8 0",
                     busy_n, rdy_seen);
        end
        checks++;
        if ({bus1.y, bus1.x, bus1.flags, bus1.err, bus1.busy} !==
            {16'hFE01, 4'b0000, 1'b0, 1'b0} ||
            {bus1.x, bus1.y, bus1.flags, bus1.err} !== e) begin
            errors++;
            $display("FAIL mul_result: yx=%h fl=%b err=%b busy=%b, want fe01 0000 0 0",
                     {bus1.y, bus1.x}, bus1.flags, bus1.err, bus1.busy);
        end
        step();
        checks++;
        if (bus1.out_valid !== 1'b0 || bus1.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL mul_drain: vld=%b rdy=%b, want 0 1",
                     bus1.out_valid, bus1.in_ready);
        end
    endtask

    task automatic test_back_to_back();
        res_t e [3];
        res_t e8;
        res_t e9;
        bus1.out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus1.in_valid = 1'b1;
            bus1.opcode = 5'(8 + i);
            bus1.a = 8'($urandom);
            bus1.b = 8'($urandom);
            e[i] = model(bus1.opcode, bus1.a, bus1.b, 1'b0, 1'b1);
            step();
            checks++;
            if (bus1.out_valid !== 1'b1 ||
                {bus1.x, bus1.y, bus1.flags, bus1.err} !== e[i]) begin
                errors++;
                $display("FAIL b2b_%0d: vld=%b got %h, want %h",
                         i, bus1.out_valid,
                         {bus1.x, bus1.y, bus1.flags, bus1.err}, e[i]);
            end
        end
        bus1.in_valid = 1'b0;
        step();
        bus1.out_ready = 1'b0;
        bus1.in_valid = 1'b1; bus1.opcode = OP_AND;
        bus1.a = 8'($urandom); bus1.b = 8'($urandom);
        e8 = model(OP_AND, bus1.a, bus1.b, 1'b0, 1'b1);
        step();
        bus1.opcode = OP_OR;
        bus1.a = 8'($urandom); bus1.b = 8'($urandom);
        e9 = model(OP_OR, bus1.a, bus1.b, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (bus1.in_ready !== 1'b0 || bus1.out_valid !== 1'b1 ||
                {bus1.x, bus1.y, bus1.flags, bus1.err} !== e8) begin
                errors++;
                $display("FAIL hold_%0d: rdy=%b vld=%b got %h, want rdy=0 vld=1 %h",
                         i, bus1.in_ready, bus1.out_valid,
                         {bus1.x, bus1.y, bus1.flags, bus1.err}, e8);
            end
            step();
        end
        bus1.out_ready = 1'b1;
        #1;
        checks++;
        if (bus1.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL hold_release: rdy=%b, want 1", bus1.in_ready);
        end
        step();
        bus1.in_valid = 1'b0;
        checks++;
        if (bus1.out_valid !== 1'b1 ||
            {bus1.x, bus1.y, bus1.flags, bus1.err} !== e9) begin
            errors++;
            $display("FAIL replace: vld=%b got %h, want 1 %h", bus1.out_valid,
                     {bus1.x, bus1.y, bus1.flags, bus1.err}, e9);
        end
        step();
    endtask

    task automatic test_illegal();
        logic [7:0] ra;
        logic [7:0] rb;
        ra = 8'($urandom);
        rb = 8'($urandom);
        bus1.in_valid = 1'b1; bus1.opcode = 5'd20;
        bus1.a = 8'h12; bus1.b = 8'h34;
        bus2.in_valid = 1'b1; bus2.opcode = OP_MUL;
        bus2.a = ra; bus2.b = rb;
        step();
        bus1.in_valid = 1'b0;
        bus2.in_valid = 1'b0;
        checks++;
        if ({bus1.out_valid, bus1.x, bus1.y, bus1.flags, bus1.err} !==
            {1'b1, 8'h12, 8'h34, 4'b0000, 1'b1}) begin
            errors++;
            $display("FAIL illegal20: vld=%b x=%h y=%h fl=%b err=%b, want 1 12 34 0000 1",
                     bus1.out_valid, bus1.x, bus1.y, bus1.flags, bus1.err);
        end
        checks++;
        if ({bus2.out_valid, bus2.busy, bus2.x, bus2.y, bus2.flags, bus2.err} !==
            {2'b10, ra, rb, 4'b0000, 1'b1}) begin
            errors++;
            $display("FAIL illegal_mul: vld=%b busy=%b x=%h y=%h fl=%b err=%b, want 1 0 %h %h 0000 1",
                     bus2.out_valid, bus2.busy, bus2.x, bus2.y, bus2.flags,
                     bus2.err, ra, rb);
        end
        step();
    endtask

    task automatic test_signed();
        res_t e;
        bus1.in_valid = 1'b1; bus1.opcode = OP_GT; bus1.a = 8'h01; bus1.b = 8'hFF;
        bus2.in_valid = 1'b1; bus2.opcode = OP_GT; bus2.a = 8'h01; bus2.b = 8'hFF;
        step();
        checks++;
        if (bus2.x !== 8'h01 || bus1.x !== 8'h00) begin
            errors++;
            $display("FAIL cmp_sign: signed x=%h unsigned x=%h, want 01 00",
                     bus2.x, bus1.x);
        end
        bus1.in_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            bus2.opcode = (i % 2 == 0) ? OP_GT : OP_LT;
            bus2.a = 8'($urandom);
            bus2.b = 8'($urandom);
            e = model(bus2.opcode, bus2.a, bus2.b, 1'b1, 1'b0);
            step();
            checks++;
            if ({bus2.x, bus2.y, bus2.flags, bus2.err} !== e) begin
                errors++;
                $display("FAIL cmp_rand_%0d: got %h, want %h", i,
                         {bus2.x, bus2.y, bus2.flags, bus2.err}, e);
            end
        end
        bus2.in_valid = 1'b0;
        step();
    endtask

    task automatic test_mul_reset();
        bus1.in_valid = 1'b1; bus1.opcode = OP_MUL;
        bus1.a = 8'($urandom); bus1.b = 8'($urandom); bus1.out_ready = 1'b1;
        step();
        bus1.in_valid = 1'b0;
        step();
        step();
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        #1;
        checks++;
        if ({bus1.busy, bus1.in_ready, bus1.out_valid} !== 3'b010) begin
            errors++;
            $display("FAIL mul_abort: busy=%b rdy=%b vld=%b, want 0 1 0",
                     bus1.busy, bus1.in_ready, bus1.out_valid);
        end
        for (int i = 0; i < 14; i++) begin
            step();
            checks++;
            if (bus1.out_valid !== 1'b0 || bus1.busy !== 1'b0) begin
                errors++;
                $display("FAIL mul_abort_quiet_%0d: vld=%b busy=%b, want 0 0",
                         i, bus1.out_valid, bus1.busy);
            end
        end
    endtask

    task automatic test_random();
        res_t q [$];
        res_t e;
        res_t got;
        for (int i = 0; i < 400; i++) begin
            bus1.in_valid  = ($urandom_range(0, 3) != 0);
            bus1.opcode    = ($urandom_range(0, 9) == 0) ? OP_MUL
                                                         : 5'($urandom_range(0, 31));
            bus1.a         = 8'($urandom);
            bus1.b         = 8'($urandom);
            bus1.out_ready = ($urandom_range(0, 3) != 0);
            #1;
            if (bus1.out_valid && bus1.out_ready) begin
                got = {bus1.x, bus1.y, bus1.flags, bus1.err};
                checks++;
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL rand_extra: unexpected result %h", got);
                end else begin
                    e = q.pop_front();
                    if (got !== e) begin
                        errors++;
                        $display("FAIL rand_%0d: got %h, want %h", i, got, e);
                    end
                end
            end
            if (bus1.in_valid && bus1.in_ready) begin
                q.push_back(model(bus1.opcode, bus1.a, bus1.b, 1'b0, 1'b1));
            end
            step();
        end
        bus1.in_valid  = 1'b0;
        bus1.out_ready = 1'b1;
        for (int k = 0; k < 40 && q.size() > 0; k++) begin
            #1;
            if (bus1.out_valid) begin
                got = {bus1.x, bus1.y, bus1.flags, bus1.err};
                e = q.pop_front();
                checks++;
                if (got !== e) begin
                    errors++;
                    $display("FAIL rand_drain: got %h, want %h", got, e);
                end
            end
            step();
        end
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL rand_timeout: %0d results missing, want 0", q.size());
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_sub();
        test_mul();
        test_back_to_back();
        test_illegal();
        test_signed();
        test_mul_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
